// File: rtl/ad_fifo_pkg.sv
// ad_fifo_pkg: shared constants and helpers for the multi-channel FIFO.
//   clog2        - constant ceil(log2) used to size pointers and addresses.
//   RD_LAT_BASE  - read latency (cycles from accepted read to o_rd_vld)
//                  without the optional output register stage.
//   RD_LAT_OREG  - read latency with AD_MC_FIFO_OUT_REG_EN defined.
package ad_fifo_pkg;

  localparam int RD_LAT_BASE = 2;
  localparam int RD_LAT_OREG = 3;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/ad_sdp_ram.sv
// ad_sdp_ram: simple dual-port inferred block RAM, one write port and one
// read port on the same clock. Both the read address and the read data are
// registered, so data for a read issued at edge T is presented after edge T+1.
// Ports:
//   i_clk, i_rst_n           clock, async active-low reset (control/output only)
//   i_wr_en/i_wr_addr/i_wr_data   write port
//   i_rd_en/i_rd_addr        read request
//   o_rd_data                registered read data (holds between reads)
// The array itself has no reset.
module ad_sdp_ram
  import ad_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 33,
  parameter  int DEPTH      = 128,
  localparam int ADDR_W     = clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [ADDR_W-1:0]     i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_W-1:0]     i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     rd_addr_reg;
  logic                  rd_en_reg;
  logic [DATA_WIDTH-1:0] rd_data_reg;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
  end

  // Address register carries no reset so it maps onto the BRAM address latch.
  always_ff @(posedge i_clk) begin
    if (i_rd_en) rd_addr_reg <= i_rd_addr;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_en_reg   <= 1'b0;
      rd_data_reg <= '0;
    end else begin
      rd_en_reg <= i_rd_en;
      if (rd_en_reg) rd_data_reg <= mem[rd_addr_reg];
    end
  end

  assign o_rd_data = rd_data_reg;

endmodule

// File: rtl/ad_mc_sync_fifo.sv
// ad_mc_sync_fifo: CH_NUM logical FIFOs sharing one block RAM; channel k owns
// RAM words [k*CH_DEPTH, (k+1)*CH_DEPTH). Per-channel pointers, level,
// full/empty and synchronous flush. Registered read path, latency 2
// (latency 3 when the macro AD_MC_FIFO_OUT_REG_EN is defined, which adds an
// output register stage on o_rd_data/o_rd_vld/o_rd_ch).
// Ports:
//   i_clk, i_rst_n             clock, async active-low reset
//   i_wr_en/i_wr_ch/i_wr_data  write request
//   i_rd_en/i_rd_ch            read request
//   i_flush                    per-channel flush (one bit per channel)
//   o_rd_data/o_rd_vld/o_rd_ch read result
//   o_empty/o_full/o_level     per-channel status (level k at [k*(PTR_W+1) +: PTR_W+1])
//   o_ovf/o_udf                rejected-write / rejected-read pulses
module ad_mc_sync_fifo
  import ad_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 33,
  parameter  int CH_NUM     = 4,
  parameter  int CH_DEPTH   = 32,
  localparam int CH_W       = clog2(CH_NUM),
  localparam int PTR_W      = clog2(CH_DEPTH)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_wr_en,
  input  logic [CH_W-1:0]             i_wr_ch,
  input  logic [DATA_WIDTH-1:0]       i_wr_data,
  input  logic                        i_rd_en,
  input  logic [CH_W-1:0]             i_rd_ch,
  input  logic [CH_NUM-1:0]           i_flush,
  output logic [DATA_WIDTH-1:0]       o_rd_data,
  output logic                        o_rd_vld,
  output logic [CH_W-1:0]             o_rd_ch,
  output logic [CH_NUM-1:0]           o_empty,
  output logic [CH_NUM-1:0]           o_full,
  output logic [CH_NUM*(PTR_W+1)-1:0] o_level,
  output logic                        o_ovf,
  output logic                        o_udf
);

  localparam int LVL_W  = PTR_W + 1;
  localparam int ADDR_W = CH_W + PTR_W;

  logic [PTR_W-1:0]      wptr_all [CH_NUM];
  logic [PTR_W-1:0]      rptr_all [CH_NUM];
  logic [CH_NUM-1:0]     full_all;
  logic [CH_NUM-1:0]     empty_all;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ovf_reg;
  logic                  udf_reg;
  logic                  rd_vld_s1_reg;
  logic                  rd_vld_s2_reg;
  logic [CH_W-1:0]       rd_ch_s1_reg;
  logic [CH_W-1:0]       rd_ch_s2_reg;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  // Flags are registered, so acceptance uses the state at the start of the
  // cycle: a write+read on an empty channel accepts only the write, and on a
  // full channel only the read. Flush silently swallows both.
  assign wr_acc = i_wr_en && !full_all[i_wr_ch]  && !i_flush[i_wr_ch];
  assign rd_acc = i_rd_en && !empty_all[i_rd_ch] && !i_flush[i_rd_ch];

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
      logic             wr_hit;
      logic             rd_hit;
      logic [PTR_W-1:0] wptr_reg;
      logic [PTR_W-1:0] rptr_reg;
      logic [LVL_W-1:0] level_reg;
      logic [LVL_W-1:0] level_next;
      logic             full_reg;
      logic             empty_reg;

      assign wr_hit = wr_acc && (i_wr_ch == CH_W'(gi));
      assign rd_hit = rd_acc && (i_rd_ch == CH_W'(gi));

      always_comb begin
        level_next = level_reg;
        if (wr_hit && !rd_hit)      level_next = level_reg + LVL_W'(1);
        else if (rd_hit && !wr_hit) level_next = level_reg - LVL_W'(1);
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          wptr_reg  <= '0;
          rptr_reg  <= '0;
          level_reg <= '0;
          full_reg  <= 1'b0;
          empty_reg <= 1'b1;
        end else if (i_flush[gi]) begin
          wptr_reg  <= '0;
          rptr_reg  <= '0;
          level_reg <= '0;
          full_reg  <= 1'b0;
          empty_reg <= 1'b1;
        end else begin
          if (wr_hit) wptr_reg <= wptr_reg + PTR_W'(1);
          if (rd_hit) rptr_reg <= rptr_reg + PTR_W'(1);
          level_reg <= level_next;
          full_reg  <= (level_next == LVL_W'(CH_DEPTH));
          empty_reg <= (level_next == '0);
        end
      end

      assign wptr_all[gi]                 = wptr_reg;
      assign rptr_all[gi]                 = rptr_reg;
      assign full_all[gi]                 = full_reg;
      assign empty_all[gi]                = empty_reg;
      assign o_level[gi*LVL_W +: LVL_W]   = level_reg;
    end
  endgenerate

  assign o_full  = full_all;
  assign o_empty = empty_all;

  // Channel index in the address MSBs keeps channel regions disjoint.
  ad_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (CH_NUM * CH_DEPTH)
  ) u_ram (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (wr_acc),
    .i_wr_addr ({i_wr_ch, wptr_all[i_wr_ch]}),
    .i_wr_data (i_wr_data),
    .i_rd_en   (rd_acc),
    .i_rd_addr ({i_rd_ch, rptr_all[i_rd_ch]}),
    .o_rd_data (ram_rd_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_reg       <= 1'b0;
      udf_reg       <= 1'b0;
      rd_vld_s1_reg <= 1'b0;
      rd_vld_s2_reg <= 1'b0;
      rd_ch_s1_reg  <= '0;
      rd_ch_s2_reg  <= '0;
    end else begin
      ovf_reg       <= i_wr_en && full_all[i_wr_ch]  && !i_flush[i_wr_ch];
      udf_reg       <= i_rd_en && empty_all[i_rd_ch] && !i_flush[i_rd_ch];
      rd_vld_s1_reg <= rd_acc;
      rd_vld_s2_reg <= rd_vld_s1_reg;
      if (rd_acc)        rd_ch_s1_reg <= i_rd_ch;
      if (rd_vld_s1_reg) rd_ch_s2_reg <= rd_ch_s1_reg;
    end
  end

  assign o_ovf = ovf_reg;
  assign o_udf = udf_reg;

`ifdef AD_MC_FIFO_OUT_REG_EN
  logic                  rd_vld_o_reg;
  logic [CH_W-1:0]       rd_ch_o_reg;
  logic [DATA_WIDTH-1:0] rd_data_o_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_vld_o_reg  <= 1'b0;
      rd_ch_o_reg   <= '0;
      rd_data_o_reg <= '0;
    end else begin
      rd_vld_o_reg  <= rd_vld_s2_reg;
      rd_ch_o_reg   <= rd_ch_s2_reg;
      rd_data_o_reg <= ram_rd_data;
    end
  end

  assign o_rd_vld  = rd_vld_o_reg;
  assign o_rd_ch   = rd_ch_o_reg;
  assign o_rd_data = rd_data_o_reg;
`else
  assign o_rd_vld  = rd_vld_s2_reg;
  assign o_rd_ch   = rd_ch_s2_reg;
  assign o_rd_data = ram_rd_data;
`endif

endmodule
